accel_spi_reader: RTL and testbench

//  SPI master for the ADXL345 accelerometer. Sits directly upstream of the movement detector.

---
 rtl/accel_spi_reader.sv | 136 +++++++++++++
 tb/tb_accel_spi_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_reader.sv
// accel_spi_reader: ADXL345 SPI master (mode 3) that enables measurement, then burst-reads X
// and publishes a scaled, saturated signed 8-bit sample with a completed/rescan handshake.
module accel_spi_reader #(
    parameter int         CLK_DIV = 25,
    parameter int         CS_GAP  = 50,
    parameter int         SHIFT   = 1,
    parameter logic [7:0] PWR_VAL = 8'h08
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rescan,
    output logic       o_completed,
    output logic [7:0] o_x_reg,
    output logic       o_spi_cs_n,
    output logic       o_spi_sclk,
    output logic       o_spi_mosi,
    input  logic       i_spi_miso
);
    localparam int CNT_MAX = (CS_GAP > CLK_DIV) ? CS_GAP : CLK_DIV;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {INIT_GAP, INIT_WR, GAP, READ, DONE} state_t;

    state_t             r_state, w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_phase;
    logic [4:0]         r_bit;
    logic [23:0]        r_tx;
    logic [15:0]        r_rx;
    logic [1:0]         r_miso_sync;
    logic               r_cs_n, r_sclk, r_mosi, r_completed;
    logic [7:0]         r_x;
    logic               w_term, w_start, w_rise, w_fall, w_last, w_end;
    logic [23:0]        w_frame;
    logic signed [15:0] w_sample, w_scaled;
    logic [7:0]         w_sat;

    assign w_term = r_cnt == CW'((r_state == INIT_GAP || r_state == GAP) ? CS_GAP - 1 : CLK_DIV - 1);

    // r_phase: 0 = SCLK low half, 1 = SCLK high half, 2 = trailing CS hold after the last bit
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_last       = 1'b0;
        w_end        = 1'b0;
        w_frame      = (r_state == GAP) ? {8'hF2, 16'h0000} : {8'h2D, PWR_VAL, 8'h00};
        case (r_state)
            INIT_GAP, GAP: begin
                if (w_term) begin
                    w_state_next = (r_state == GAP) ? READ : INIT_WR;
                    w_start      = 1'b1;
                end
            end
            INIT_WR, READ: begin
                if (w_term) begin
                    w_rise = r_phase == 2'd0;
                    w_fall = r_phase == 2'd1 && r_bit != 5'd0;
                    w_last = r_phase == 2'd1 && r_bit == 5'd0;
                    w_end  = r_phase == 2'd2;
                    if (w_end)
                        w_state_next = (r_state == READ) ? DONE : GAP;
                end
            end
            DONE:    w_state_next = i_rescan ? GAP : DONE;
            default: w_state_next = INIT_GAP;
        endcase
    end

    always_ff @(posedge i_clk) begin
        r_state <= !i_reset_n ? INIT_GAP : w_state_next;
    end

    // DATAX0 arrives first, so it sits in the upper byte of the receive shifter
    assign w_sample = {r_rx[7:0], r_rx[15:8]};
    assign w_scaled = w_sample >>> SHIFT;
    assign w_sat    = (w_scaled > 16'sd127) ? 8'h7F : (w_scaled < -16'sd128) ? 8'h80 : w_scaled[7:0];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_phase     <= 2'd0;
            r_bit       <= 5'd0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_miso_sync <= 2'b00;
            r_cs_n      <= 1'b1;
            r_sclk      <= 1'b1;
            r_mosi      <= 1'b0;
            r_completed <= 1'b0;
            r_x         <= 8'h00;
        end else begin
            r_miso_sync <= {r_miso_sync[0], i_spi_miso};
            r_cnt       <= (w_term || r_state == DONE) ? '0 : r_cnt + 1'b1;
            if (w_start) begin
                r_cs_n  <= 1'b0;
                r_sclk  <= 1'b0;
                r_mosi  <= w_frame[23];
                r_tx    <= {w_frame[22:0], 1'b0};
                r_bit   <= (r_state == GAP) ? 5'd23 : 5'd15;
                r_phase <= 2'd0;
            end
            if (w_rise) begin
                r_sclk  <= 1'b1;
                r_rx    <= {r_rx[14:0], r_miso_sync[1]};
                r_phase <= 2'd1;
            end
            if (w_fall) begin
                r_sclk  <= 1'b0;
                r_mosi  <= r_tx[23];
                r_tx    <= {r_tx[22:0], 1'b0};
                r_bit   <= r_bit - 1'b1;
                r_phase <= 2'd0;
            end
            if (w_last)
                r_phase <= 2'd2;
            if (w_end) begin
                r_cs_n <= 1'b1;
                r_mosi <= 1'b0;
                if (r_state == READ) begin
                    r_x         <= w_sat;
                    r_completed <= 1'b1;
                end
            end
            if (r_state == DONE && i_rescan)
                r_completed <= 1'b0;
        end
    end

    assign o_completed = r_completed;
    assign o_x_reg     = r_x;
    assign o_spi_cs_n  = r_cs_n;
    assign o_spi_sclk  = r_sclk;
    assign o_spi_mosi  = r_mosi;
endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader: ADXL345 slave model plus frame/handshake reference model driving accel_spi_reader
// with random and boundary X samples.
module tb_accel_spi_reader;
    localparam int         CLK_DIV = 2;
    localparam int         CS_GAP  = 4;
    localparam int         SHIFT   = 1;
    localparam logic [7:0] PWR_VAL = 8'h08;

    logic       clk = 1'b0, reset_n = 1'b0, rescan = 1'b0, spi_miso = 1'b0;
    logic       completed, cs_n, sclk, mosi;
    logic [7:0] x_reg;

    int   n_chk = 0, n_err = 0, cyc = 0, frames_done = 0, n_rises = 0, n_stray = 0;
    logic rst_q = 1'b0;
    logic rnd_data = 1'b0;
    logic [7:0] fix_d0 = 8'hA0, fix_d1 = 8'h00;
    logic [15:0] sat_vec [4] = '{16'h0400, 16'hFC00, 16'hFF01, 16'hFFFE};

    logic        in_frame = 1'b0, want_init = 1'b1, pcs = 1'b1, psclk = 1'b1, pcomp = 1'b0;
    logic [7:0]  px = 8'h00, d0 = 8'h00, d1 = 8'h00;
    int          bits = 0, last_bits = 0, start_cyc = 0, end_cyc = 0, last_rise = 0;
    logic [23:0] word = '0, resp = '0;

    accel_spi_reader #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .SHIFT(SHIFT), .PWR_VAL(PWR_VAL)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_rescan(rescan), .o_completed(completed),
        .o_x_reg(x_reg), .o_spi_cs_n(cs_n), .o_spi_sclk(sclk), .o_spi_mosi(mosi), .i_spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Floor division by 2**SHIFT, then clamp into the signed 8-bit range
    function automatic logic [7:0] exp_x(input logic [7:0] lo, input logic [7:0] hi);
        logic signed [15:0] s16;
        int v, div;
        s16 = {hi, lo};
        v   = s16;
        div = 1 << SHIFT;
        v   = (v >= 0) ? v / div : -((-v + div - 1) / div);
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    always @(negedge clk) begin
        if (!rst_q) begin
            in_frame  = 1'b0;
            want_init = 1'b1;
            last_bits = 0;
        end else begin
            if (pcs && !cs_n) begin
                if (last_bits == 16) check("cs_gap", cyc - end_cyc, CS_GAP);
                in_frame  = 1'b1;
                start_cyc = cyc;
                bits      = 0;
                word      = '0;
                d0        = rnd_data ? 8'($urandom) : fix_d0;
                d1        = rnd_data ? 8'($urandom) : fix_d1;
                resp      = {8'($urandom), d0, d1};
                spi_miso  = resp[23];
            end
            if (in_frame && !cs_n && !psclk && sclk) begin
                if (bits > 0) check("sclk_period", cyc - last_rise, 2 * CLK_DIV);
                last_rise = cyc;
                word      = {word[22:0], mosi};
                bits++;
                n_rises++;
                if (bits < 24) spi_miso = resp[23 - bits];
            end
            if (in_frame && !pcs && cs_n) begin
                check("frame_len", cyc - start_cyc, (2 * bits + 1) * CLK_DIV);
                check("frame_kind", bits, want_init ? 16 : 24);
                if (bits == 16) begin
                    check("wr_word", word[15:0], {8'h2D, PWR_VAL});
                    check("wr_no_completed", completed, 1'b0);
                end else begin
                    check("rd_word", word, 24'hF20000);
                    check("x_reg", x_reg, exp_x(d0, d1));
                    check("completed", completed, 1'b1);
                end
                want_init = 1'b0;
                in_frame  = 1'b0;
                last_bits = bits;
                end_cyc   = cyc;
                frames_done++;
            end
            if (pcs && cs_n && sclk != psclk) n_stray++;
            if (cs_n && mosi) n_stray++;
            if (x_reg != px && !(!pcs && cs_n)) n_stray++;
            if (completed && !pcomp && !(!pcs && cs_n)) n_stray++;
        end
        pcs   = cs_n;
        psclk = sclk;
        px    = x_reg;
        pcomp = completed;
    end

    task automatic do_read(input int hold);
        int f0;
        f0     = frames_done;
        rescan = 1'b1;
        for (int i = 0; i < 50 && completed; i++) @(negedge clk);
        check("rescan_clears", completed, 1'b0);
        repeat (hold) @(negedge clk);
        rescan = 1'b0;
        for (int i = 0; i < 1000 && !completed; i++) @(negedge clk);
        @(negedge clk);
        check("one_read", frames_done, f0 + 1);
    endtask

    initial begin
        int f0, r0;
        logic [7:0] x0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_sclk", sclk, 1'b1);
        check("rst_mosi", mosi, 1'b0);
        check("rst_x_reg", x_reg, 8'h00);
        check("rst_completed", completed, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 2000 && frames_done < 2; i++) @(negedge clk);
        @(negedge clk);
        check("first_frames", frames_done, 2);
        check("first_x_reg", x_reg, 8'h50);
        check("first_completed", completed, 1'b1);

        foreach (sat_vec[i]) begin
            fix_d0 = sat_vec[i][7:0];
            fix_d1 = sat_vec[i][15:8];
            do_read(i * 20);
        end
        check("sat_last_x_reg", x_reg, 8'hFF);
        rnd_data = 1'b1;
        repeat (8) do_read($urandom_range(0, 80));

        f0 = frames_done;
        r0 = n_rises;
        x0 = x_reg;
        repeat (1000) @(negedge clk);
        check("idle_frames", frames_done, f0);
        check("idle_rises", n_rises, r0);
        check("idle_x_reg", x_reg, x0);
        check("idle_completed", completed, 1'b1);

        rescan = 1'b1;
        for (int i = 0; i < 50 && completed; i++) @(negedge clk);
        rescan = 1'b0;
        for (int i = 0; i < 500 && !(!cs_n && bits == 10); i++) @(negedge clk);
        check("abort_reached_bit10", {!cs_n, bits == 10}, 2'b11);
        repeat (CLK_DIV) @(negedge clk);
        f0      = frames_done;
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_cs_n", cs_n, 1'b1);
        check("abort_sclk", sclk, 1'b1);
        check("abort_mosi", mosi, 1'b0);
        check("abort_completed", completed, 1'b0);
        check("abort_x_reg", x_reg, 8'h00);
        reset_n = 1'b1;
        for (int i = 0; i < 500 && frames_done == f0; i++) @(negedge clk);
        @(negedge clk);
        check("abort_frames", frames_done, f0 + 1);
        check("abort_reinit_bits", last_bits, 16);
        for (int i = 0; i < 500 && !completed; i++) @(negedge clk);
        @(negedge clk);
        check("abort_reread", frames_done, f0 + 2);

        f0     = frames_done;
        rescan = 1'b1;
        for (int i = 0; i < 20000 && frames_done < f0 + 100; i++) @(negedge clk);
        rescan = 1'b0;
        check("b2b_count", frames_done >= f0 + 100, 1'b1);
        for (int i = 0; i < 1000 && !(completed && cs_n); i++) @(negedge clk);
        @(negedge clk);
        check("b2b_settled", completed, 1'b1);

        check("stray_activity", n_stray, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
